// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state type and counter sizing for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Bit counter width: enough to hold WIDTH-1, never narrower than one bit
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder cell
module full_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  // Combinational sum and majority carry
  always_comb begin
    o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
    o_carry = (i_bit1 & i_bit2) | (i_bit1 & i_carry) | (i_bit2 & i_carry);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer; SERIAL_ADDER_SUB_EN adds i_sub for A-B
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;
  logic             sub_sel;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = i_sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so only the B operand and the carry seed change
  always_comb begin
    b_in   = sub_sel ? ~i_b : i_b;
    cin_in = sub_sel ? 1'b1 : i_carry;
  end

  // New sum bit enters at the MSB; concatenation keeps this legal for WIDTH=1
  always_comb begin
    res_cat  = {fa_sum, res_sh};
    res_next = res_cat[WIDTH:1];
  end

  full_adder u_full_adder (
    .i_bit1  (a_sh[0]),
    .i_bit2  (b_sh[0]),
    .i_carry (carry_q),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // Sequencer: accept operands, shift one bit per cycle, hold result until taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_sum   <= '0;
      o_carry <= 1'b0;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh    <= i_a;
            b_sh    <= b_in;
            carry_q <= cin_in;
            cnt     <= '0;
            state   <= RUN;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        RUN: begin
          res_sh  <= res_next;
          carry_q <= fa_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          if (cnt == LAST) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_sum   <= res_next;
            o_carry <= fa_carry;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
